// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlymeas.sv
// ============================================================================
// gf180mcu_fd_sc_mcu9t5v0__dlymeas
// Measures delay-chain round-trip time in CLK cycles via a synchronized return.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gf180mcu_fd_sc_mcu9t5v0__dlymeas #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             RET,
  output logic             LAUNCH,
  output logic             BUSY,
  output logic             DONE,
  output logic             TIMEOUT,
  output logic [CNT_W-1:0] COUNT
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_state_nx;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_ret_s;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nx;
  logic                   r_launch;
  logic                   w_launch_nx;
  logic                   r_done;
  logic                   w_done_nx;
  logic                   r_timeout;
  logic                   w_timeout_nx;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_count_nx;

  // RET is asynchronous; only the last synchronizer stage is ever used.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], RET};
    end
  end

  assign w_ret_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_launch  <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_launch  <= w_launch_nx;
      r_done    <= w_done_nx;
      r_timeout <= w_timeout_nx;
      r_count   <= w_count_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_launch_nx  = r_launch;
    w_done_nx    = 1'b0;
    w_timeout_nx = r_timeout;
    w_count_nx   = r_count;
    case (r_state)
      IDLE: begin
        // A return still high from a previous launch would corrupt the count.
        if (START && !w_ret_s) begin
          w_launch_nx  = 1'b1;
          w_cnt_nx     = '0;
          w_timeout_nx = 1'b0;
          w_state_nx   = MEASURE;
        end
      end
      MEASURE: begin
        if (w_ret_s) begin
          w_count_nx  = r_cnt;
          w_launch_nx = 1'b0;
          w_cnt_nx    = '0;
          w_state_nx  = DRAIN;
        end else if (r_cnt == c_cnt_max) begin
          w_count_nx   = c_cnt_max;
          w_timeout_nx = 1'b1;
          w_launch_nx  = 1'b0;
          w_cnt_nx     = '0;
          w_state_nx   = DRAIN;
        end else begin
          w_cnt_nx = r_cnt + c_cnt_one;
        end
      end
      DRAIN: begin
        // Wait for the falling return so the next launch starts clean.
        if (!w_ret_s) begin
          w_done_nx  = 1'b1;
          w_state_nx = IDLE;
        end else if (r_cnt == c_cnt_max) begin
          w_timeout_nx = 1'b1;
          w_done_nx    = 1'b1;
          w_state_nx   = IDLE;
        end else begin
          w_cnt_nx = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  assign LAUNCH  = r_launch;
  assign BUSY    = (r_state != IDLE);
  assign DONE    = r_done;
  assign TIMEOUT = r_timeout;
  assign COUNT   = r_count;

endmodule

`default_nettype wire

// File: doc/gf180mcu_fd_sc_mcu9t5v0__dlymeas.md
GF180MCU_FD_SC_MCU9T5V0__DLYMEAS -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__dlymeas

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, the width of the cycle counter and the COUNT result.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2 (legal 2..4), the number of flops synchronizing RET.
REQ-003 The block SHALL have port CLK, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port RN, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port START, input, 1, a measurement request sampled on CLK.
REQ-006 The block SHALL have port RET, input, 1, the returned edge from the delay-chain output Z; it is asynchronous to CLK.
REQ-007 The block SHALL have port LAUNCH, output, 1, a registered launch level driving the delay-chain input I.
REQ-008 The block SHALL have port BUSY, output, 1, high while a measurement is in progress.
REQ-009 The block SHALL have port DONE, output, 1, a one-cycle completion pulse.
REQ-010 The block SHALL have port TIMEOUT, output, 1, high when the last measurement failed to see a return.
REQ-011 The block SHALL have port COUNT, output, CNT_W, the measured cycle count.
REQ-012 Under USE_POWER_PINS the block SHALL add ports VDD and VSS, inout, 1, for supply and ground.

Function
REQ-013 RET SHALL pass through a SYNC_STAGES flop chain; ret_s is the last stage, and no other logic SHALL sample RET.
REQ-014 The FSM SHALL have states IDLE, MEASURE and DRAIN; BUSY SHALL be 1 exactly when the state is not IDLE.
REQ-015 In IDLE, START=1 with ret_s=0 SHALL be accepted as follows:
- LAUNCH is set to 1, the counter to 0 and TIMEOUT to 0;
- the state moves to MEASURE.
REQ-016 In IDLE, START=1 with ret_s=1 SHALL be ignored (no state change, no output change).
REQ-017 START SHALL be ignored in MEASURE and DRAIN; no queuing occurs.
REQ-018 In MEASURE, each edge with ret_s=0 and counter < 2^CNT_W-1 SHALL increment the counter by 1.
REQ-019 In MEASURE, an edge with ret_s=1 SHALL:
- load COUNT with the counter value;
- clear LAUNCH and enter DRAIN.
REQ-020 In MEASURE, an edge with ret_s=0 and counter = 2^CNT_W-1 SHALL:
- load COUNT with all ones and set TIMEOUT=1;
- clear LAUNCH and enter DRAIN.
REQ-021 With RET changing just after edge k+D, where k is the LAUNCH-rising edge, COUNT SHALL equal D+SYNC_STAGES; a zero-delay loop therefore gives COUNT=SYNC_STAGES.
REQ-022 In DRAIN, the counter SHALL restart at 0 on entry; the first edge with ret_s=0 SHALL pulse DONE for exactly one cycle and return to IDLE.
REQ-023 If DRAIN reaches counter = 2^CNT_W-1 with ret_s still 1 (RET stuck high), the block SHALL set TIMEOUT=1, leave COUNT unchanged, pulse DONE and return to IDLE.
REQ-024 COUNT and TIMEOUT SHALL hold their values from DONE until the next accepted START; COUNT is not cleared on START.
REQ-025 The counter SHALL never wrap; arithmetic is unsigned CNT_W-bit.
REQ-026 All outputs SHALL be driven directly from flops, with BUSY decoded from the state register only.

Reset
REQ-027 RN=0 SHALL asynchronously force:
- state=IDLE;
- LAUNCH=0, BUSY=0, DONE=0, TIMEOUT=0, COUNT=0;
- counter=0 and all synchronizer flops=0.
REQ-028 Reset asserted mid-measurement SHALL drop LAUNCH without waiting for CLK.
REQ-029 After RN deasserts, the first START SHALL be accepted no earlier than the first rising CLK edge at which RN=1.

Verification
REQ-030 Zero-delay loop (RET=LAUNCH), CNT_W=8, SYNC_STAGES=2, START pulsed one cycle -> COUNT=2, TIMEOUT=0, DONE pulses once, BUSY falls in the DONE cycle.
REQ-031 RET follows LAUNCH with a 10-cycle delay -> COUNT=12, TIMEOUT=0; a second run with a 3-cycle delay -> COUNT=5.
REQ-032 RET tied 0, START pulsed -> COUNT=255 and TIMEOUT=1 with DONE, after 255 MEASURE edges plus the DRAIN exit.
REQ-033 RET held at 1 before START -> START ignored and BUSY stays 0; RET released to 0, then START -> measurement accepted.
REQ-034 START re-asserted during MEASURE, and RN pulsed low mid-MEASURE with RET delay 20 -> the extra START has no effect; on reset, LAUNCH=0 immediately and all outputs return to reset values.
